knn_stream_sorter: RTL and testbench

Parametrised successor to the single-point distance/sort pipeline in the KNN accelerator. It streams labelled 2-D training samples through a 3-stage squared-distance pipeline against a latched test point. It keeps a stable, insertion-sorted list of the K nearest samples (distance plus label) and flags completion after the last sample drains. The block sits between the CPU-facing register file and the label-vote logic, which reads the list through an indexed read port.

---
 rtl/knn_stream_sorter.sv | 196 +++++++++++++++++++
 tb/tb_knn_stream_sorter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/knn_stream_sorter.sv
// knn_stream_sorter: streams labelled 2-D samples through a squared-distance
// pipeline against a latched test point and keeps a stable, ascending list of
// the K nearest samples, readable through a combinational indexed port.
module knn_stream_sorter #(
    parameter int DW   = 16,
    parameter int K    = 10,
    parameter int LW   = 8,
    parameter int SELW = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DW-1:0]     test_x,
    input  logic [DW-1:0]     test_y,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DW-1:0]     in_x,
    input  logic [DW-1:0]     in_y,
    input  logic [LW-1:0]     in_label,
    input  logic              in_last,
    output logic              done,
    output logic [SELW-1:0]   count,
    input  logic [SELW-1:0]   rd_sel,
    output logic              rd_valid,
    output logic [2*DW:0]     rd_dist,
    output logic [LW-1:0]     rd_label
);

    localparam int DSW = 2*DW + 1;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
    state_t state, state_nxt;

    logic              accept;
    logic [DW-1:0]     tx, ty;

    // Input capture stage
    logic              p0_valid, p0_last;
    logic [DW-1:0]     p0_x, p0_y;
    logic [LW-1:0]     p0_label;
    // S1: signed differences
    logic              s1_valid, s1_last;
    logic [DW:0]       s1_dx, s1_dy;
    logic [LW-1:0]     s1_label;
    // S2: squares
    logic              s2_valid, s2_last;
    logic [2*DW-1:0]   s2_sqx, s2_sqy;
    logic [LW-1:0]     s2_label;
    // S3: summed distance
    logic              s3_valid, s3_last;
    logic [DSW-1:0]    s3_dist;
    logic [LW-1:0]     s3_label;

    logic [DW-1:0]     mag_x, mag_y;

    // Sorted neighbour list
    logic [DSW-1:0]    l_dist  [K];
    logic [LW-1:0]     l_label [K];
    logic [K-1:0]      l_valid;
    logic [K-1:0]      gt;
    logic              ins;

    // Handshake and status outputs
    always_comb begin
        in_ready = (state == RUN) && !start;
        accept   = in_valid && in_ready;
        done     = (state == DONE);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic: start overrides every state
    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = RUN;
        end else begin
            case (state)
                RUN:     if (accept && in_last) state_nxt = FLUSH;
                FLUSH:   if (s3_valid && s3_last) state_nxt = DONE;
                default: state_nxt = state;
            endcase
        end
    end

    // Test point latch
    always_ff @(posedge clk) begin
        if (rst) begin
            tx <= '0;
            ty <= '0;
        end else if (start) begin
            tx <= test_x;
            ty <= test_y;
        end
    end

    // Pipeline valid bits; start discards everything in flight
    always_ff @(posedge clk) begin
        if (rst || start) begin
            p0_valid <= 1'b0;
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s3_valid <= 1'b0;
        end else begin
            p0_valid <= accept;
            s1_valid <= p0_valid;
            s2_valid <= s1_valid;
            s3_valid <= s2_valid;
        end
    end

    // Magnitudes of the differences; |dx| <= 2^DW-1 always fits in DW bits
    always_comb begin
        mag_x = s1_dx[DW] ? DW'(-s1_dx) : s1_dx[DW-1:0];
        mag_y = s1_dy[DW] ? DW'(-s1_dy) : s1_dy[DW-1:0];
    end

    // Distance datapath with label/last riding alongside
    always_ff @(posedge clk) begin
        p0_x     <= in_x;
        p0_y     <= in_y;
        p0_label <= in_label;
        p0_last  <= in_last;

        s1_dx    <= {p0_x[DW-1], p0_x} - {tx[DW-1], tx};
        s1_dy    <= {p0_y[DW-1], p0_y} - {ty[DW-1], ty};
        s1_label <= p0_label;
        s1_last  <= p0_last;

        s2_sqx   <= (2*DW)'(mag_x) * (2*DW)'(mag_x);
        s2_sqy   <= (2*DW)'(mag_y) * (2*DW)'(mag_y);
        s2_label <= s1_label;
        s2_last  <= s1_last;

        s3_dist  <= {1'b0, s2_sqx} + {1'b0, s2_sqy};
        s3_label <= s2_label;
        s3_last  <= s2_last;
    end

    // Entries strictly farther than the new sample (empty = +inf); equal
    // distances stay ahead so the list is stable. gt is monotonic, so the
    // last entry alone tells whether the sample is kept.
    always_comb begin
        for (int unsigned i = 0; i < K; i++) begin
            gt[i] = !l_valid[i] || (l_dist[i] > s3_dist);
        end
        ins = s3_valid && gt[K-1];
    end

    // Shift-insert into the list and occupancy count
    always_ff @(posedge clk) begin
        if (rst || start) begin
            l_valid <= '0;
            count   <= '0;
        end else if (ins) begin
            if (gt[0]) begin
                l_valid[0] <= 1'b1;
                l_dist[0]  <= s3_dist;
                l_label[0] <= s3_label;
            end
            for (int unsigned i = 1; i < K; i++) begin
                if (gt[i]) begin
                    if (gt[i-1]) begin
                        l_valid[i] <= l_valid[i-1];
                        l_dist[i]  <= l_dist[i-1];
                        l_label[i] <= l_label[i-1];
                    end else begin
                        l_valid[i] <= 1'b1;
                        l_dist[i]  <= s3_dist;
                        l_label[i] <= s3_label;
                    end
                end
            end
            if (count != SELW'(K)) count <= count + SELW'(1);
        end
    end

    // Combinational read port; out-of-range or empty index reads as zero
    always_comb begin
        rd_valid = 1'b0;
        rd_dist  = '0;
        rd_label = '0;
        for (int unsigned i = 0; i < K; i++) begin
            if (rd_sel == SELW'(i) && l_valid[i]) begin
                rd_valid = 1'b1;
                rd_dist  = l_dist[i];
                rd_label = l_label[i];
            end
        end
    end

endmodule

// File: tb/tb_knn_stream_sorter.sv
// Self-checking bench for knn_stream_sorter: a queue-based reference model
// (stable K-smallest selection over accepted samples, 4-cycle visibility)
// checked every cycle, plus literal expectations for directed scenarios.
module tb_knn_stream_sorter;

    localparam int DW   = 16;
    localparam int K    = 4;
    localparam int LW   = 8;
    localparam int SELW = 8;
    localparam int NSEL = K + 2;

    logic            clk = 1'b0;
    logic            rst, start, in_valid, in_ready, in_last, done, rd_valid;
    logic [DW-1:0]   test_x, test_y, in_x, in_y;
    logic [LW-1:0]   in_label, rd_label;
    logic [SELW-1:0] count, rd_sel;
    logic [2*DW:0]   rd_dist;

    always #10 clk = ~clk;

    knn_stream_sorter #(.DW(DW), .K(K), .LW(LW), .SELW(SELW)) dut (
        .clk(clk), .rst(rst), .start(start), .test_x(test_x), .test_y(test_y),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
        .in_label(in_label), .in_last(in_last), .done(done), .count(count),
        .rd_sel(rd_sel), .rd_valid(rd_valid), .rd_dist(rd_dist), .rd_label(rd_label)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int      cyc = 0;
    bit      model_on = 0, running = 0;
    int      last_acc = -1;
    longint  mtx = 0, mty = 0;
    longint  q_dist[$];
    int      q_lab[$];
    int      q_acc[$];

    bit      p_rst, p_start, p_hs, p_last;
    longint  p_tx, p_ty, p_dist;
    int      p_lab;

    bit      e_v[K];
    longint  e_d[K];
    int      e_l[K];
    bit      exp_ready, exp_done;
    int      exp_count;

    bit      sn_v[NSEL];
    longint  sn_d[NSEL];
    int      sn_l[NSEL];
    int      sn_count;
    bit      sn_done;
    event    snap_ev;

    // model advances on each active edge
    always @(posedge clk) begin
        cyc++;
        if (p_rst) begin
            model_on = 1; running = 0; last_acc = -1;
            q_dist.delete(); q_lab.delete(); q_acc.delete();
        end else begin
            if (p_start) begin
                running = 1; last_acc = -1; mtx = p_tx; mty = p_ty;
                q_dist.delete(); q_lab.delete(); q_acc.delete();
            end
            if (p_hs) begin
                q_dist.push_back(p_dist); q_lab.push_back(p_lab); q_acc.push_back(cyc);
                if (p_last) last_acc = cyc;
            end
        end
    end

    // compare process: predicted outputs vs DUT, whole list swept via rd_sel
    always @(negedge clk) begin
        int      n_elig, best, pj, sel;
        longint  pd, bd, dx, dy;
        bit      ev;
        longint  ed;
        int      el;

        exp_ready = running && (last_acc < 0) && !start;
        p_rst   = rst;
        p_start = start;
        p_tx    = longint'($signed(test_x));
        p_ty    = longint'($signed(test_y));
        p_hs    = in_valid && exp_ready;
        p_last  = in_last;
        p_lab   = int'(in_label);
        dx      = longint'($signed(in_x)) - mtx;
        dy      = longint'($signed(in_y)) - mty;
        p_dist  = dx*dx + dy*dy;

        if (model_on) begin
            n_elig = 0;
            foreach (q_acc[i]) if (q_acc[i] + 4 <= cyc) n_elig++;
            pd = -1; pj = -1;
            for (int r = 0; r < K; r++) begin
                best = -1; bd = 0;
                for (int j = 0; j < n_elig; j++) begin
                    if ((q_dist[j] > pd || (q_dist[j] == pd && j > pj)) &&
                        (best < 0 || q_dist[j] < bd)) begin
                        best = j; bd = q_dist[j];
                    end
                end
                if (best >= 0) begin
                    e_v[r] = 1; e_d[r] = bd; e_l[r] = q_lab[best];
                    pd = bd; pj = best;
                end else begin
                    e_v[r] = 0; e_d[r] = 0; e_l[r] = 0;
                end
            end
            exp_count = (n_elig < K) ? n_elig : K;
            exp_done  = (last_acc >= 0) && (cyc >= last_acc + 4);

            sn_done  = done;
            sn_count = int'(count);
            chk("in_ready", in_ready, exp_ready);
            chk("done", done, exp_done);
            chk("count", count, exp_count);
            for (int s = 0; s < NSEL; s++) begin
                sel = (s < K) ? s : ((s == K) ? K : 200);
                rd_sel = SELW'(sel);
                #1;
                ev = (s < K) ? e_v[s] : 1'b0;
                ed = (s < K) ? e_d[s] : 0;
                el = (s < K) ? e_l[s] : 0;
                sn_v[s] = rd_valid; sn_d[s] = longint'(rd_dist); sn_l[s] = int'(rd_label);
                chk($sformatf("rd_valid[sel=%0d]", sel), rd_valid, ev);
                chk($sformatf("rd_dist[sel=%0d]", sel), rd_dist, ed);
                chk($sformatf("rd_label[sel=%0d]", sel), rd_label, el);
            end
            -> snap_ev;
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_start(input int x, input int y);
        start = 1; test_x = DW'(x); test_y = DW'(y);
        @(posedge clk); #1;
        start = 0;
    endtask

    task automatic send(input int x, input int y, input int lab, input bit last, output int acc);
        in_valid = 1; in_x = DW'(x); in_y = DW'(y); in_label = LW'(lab); in_last = last;
        @(posedge clk); #1;
        acc = cyc;
        in_valid = 0; in_last = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_done(input string name, input int acc);
        bit seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(snap_ev);
            if (sn_done) begin
                seen = 1;
                chk({name, "_done_latency"}, cyc - acc, 4);
            end
        end
        if (!seen) chk({name, "_done_timeout"}, 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic lit(input string name, input int idx, input longint d, input int l);
        chk($sformatf("%s_dist[%0d]", name, idx), sn_d[idx], d);
        chk($sformatf("%s_label[%0d]", name, idx), sn_l[idx], l);
        chk($sformatf("%s_model_dist[%0d]", name, idx), e_d[idx], d);
        chk($sformatf("%s_model_label[%0d]", name, idx), e_l[idx], l);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, x, y;
        rst = 1; start = 0; in_valid = 0; in_last = 0; in_x = '0; in_y = '0;
        in_label = '0; test_x = '0; test_y = '0; rd_sel = '0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        idle(2);
        chk("reset_in_ready", in_ready, 0);
        chk("reset_count", count, 0);
        chk("reset_done", done, 0);
        chk("reset_rd_valid", rd_valid, 0);

        // basic sort
        do_start(0, 0);
        send(3, 0, 1, 0, a); send(1, 1, 2, 0, a); send(-2, 0, 3, 0, a);
        send(0, -1, 4, 0, a); send(5, 5, 5, 1, a);
        wait_done("basic", a);
        lit("basic", 0, 1, 4); lit("basic", 1, 2, 2);
        lit("basic", 2, 4, 3); lit("basic", 3, 9, 1);
        chk("basic_count", sn_count, 4);

        // ties: all at distance 8, fifth one dropped
        do_start(0, 0);
        send(2, 2, 1, 0, a); send(-2, 2, 2, 0, a); send(2, -2, 3, 0, a);
        send(-2, -2, 4, 0, a); send(2, 2, 5, 1, a);
        wait_done("ties", a);
        for (int i = 0; i < K; i++) lit("ties", i, 8, i + 1);

        // extreme coordinates
        do_start(-32768, -32768);
        send(32767, 32767, 9, 1, a);
        wait_done("extreme", a);
        lit("extreme", 0, 64'd8589672450, 9);
        chk("extreme_count", sn_count, 1);

        // partial list
        do_start(0, 0);
        send(1, 0, 7, 0, a); send(0, 2, 8, 1, a);
        wait_done("partial", a);
        chk("partial_count", sn_count, 2);
        chk("partial_sel2_valid", sn_v[2], 0);
        chk("partial_sel2_dist", sn_d[2], 0);
        chk("partial_sel200_valid", sn_v[K+1], 0);
        chk("partial_sel200_dist", sn_d[K+1], 0);
        chk("partial_sel200_label", sn_l[K+1], 0);

        // restart mid-stream with a concurrent sample
        do_start(0, 0);
        send(1, 0, 11, 0, a); send(0, 1, 12, 0, a); send(-1, 0, 13, 0, a);
        idle(1);
        in_valid = 1; in_x = '0; in_y = '0; in_label = 8'd14; start = 1;
        test_x = '0; test_y = '0;
        #1 chk("restart_concurrent_ready", in_ready, 0);
        @(posedge clk); #1;
        in_valid = 0; start = 0;
        send(5, 0, 21, 0, a); send(0, 4, 22, 1, a);
        wait_done("restart", a);
        lit("restart", 0, 16, 22); lit("restart", 1, 25, 21);
        chk("restart_count", sn_count, 2);

        // reset mid-stream
        do_start(0, 0);
        send(1, 1, 31, 0, a); send(2, 2, 32, 0, a);
        in_valid = 1; in_x = DW'(3); in_y = '0; in_label = 8'd33; rst = 1;
        idle(2);
        rst = 0; in_valid = 0;
        idle(3);
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_count", count, 0);
        chk("midrst_done", done, 0);
        @(snap_ev);
        chk("midrst_rd_valid0", sn_v[0], 0);
        @(posedge clk); #1;

        // streaming: back-to-back random samples
        do_start(int'($urandom_range(0, 20)) - 10, int'($urandom_range(0, 20)) - 10);
        for (int i = 0; i < 1000; i++) begin
            if (i % 50 == 7) begin
                x = int'($urandom_range(0, 65535)) - 32768;
                y = int'($urandom_range(0, 65535)) - 32768;
            end else begin
                x = int'($urandom_range(0, 40)) - 20;
                y = int'($urandom_range(0, 40)) - 20;
            end
            send(x, y, i % 256, (i == 999), a);
        end
        wait_done("stream", a);
        chk("stream_count", sn_count, K);
        chk("stream_ready_after_done", in_ready, 0);
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
